// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, occupancy encoding and select-width helper for the select muxes
package mux_pkg;

  localparam int MUX_MAX_N = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  function automatic int mux_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// rtl/mux_sel_comb.sv - combinational N-way W-bit select with a defined default for out-of-range selects
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 5,
  parameter logic [W-1:0] DEFAULT_VAL = '0,
  localparam int SW = mux_sel_width(N)
) (
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_of_range
);

  if (N < 2 || N > MUX_MAX_N || W < 1) begin : g_bad_params
    $error("mux_sel_comb: illegal parameters N=%0d W=%0d", N, W);
  end

  always_comb begin
    out_data = DEFAULT_VAL;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) out_data = in_data[k*W +: W];
    end
  end

  // Constant-false when N is a power of two; the default path is then unreachable.
  assign out_of_range = ({1'b0, sel} >= (SW+1)'(N));

endmodule

// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - select mux with a registered valid/ready output stage and 2-entry skid buffer
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 5,
  parameter logic [W-1:0] DEFAULT_VAL = '0,
  localparam int SW = mux_sel_width(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err,
  input  logic           err_clr,
  output logic [1:0]     occupancy
);

  occ_state_e     state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic [W-1:0]   sel_data;
  logic           sel_oob;
  logic           ready_q;
  logic           err_q;
  logic           accept;
  logic           emit;

  mux_sel_comb #(
    .W           (W),
    .N           (N),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .in_data      (in_data),
    .sel          (in_sel),
    .out_data     (sel_data),
    .out_of_range (sel_oob)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = sel_data;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_d = sel_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = sel_data;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next occupancy so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
      if (accept && sel_oob) err_q <= 1'b1;
      else if (err_clr)      err_q <= 1'b0;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_q;
  assign sel_err   = err_q;
  assign occupancy = state_q;

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
Parametrised N-input, W-bit selector for the datapath, the next generation of the 5-input 32-bit select muxes. Adds a valid/ready registered output stage with a 2-entry skid buffer, so it can sit between pipeline stages at full throughput. Out-of-range selects produce a defined default value instead of holding the previous value. A sticky error flag records any such select.

Parameters:
W, 32, data width in bits (>=1)
N, 5, number of data inputs (2..16)
SW, $clog2(N), select width (derived; not overridable)
DEFAULT_VAL, 0, W-bit value output when the select is >= N

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_data  in  N*W  flattened inputs; input k occupies bits [k*W +: W]
in_sel  in  SW  select, sampled with in_valid
in_valid  in  1  upstream offers a beat
in_ready  out  1  block can accept a beat
out_data  out  W  selected data
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts a beat
sel_err  out  1  sticky: an out-of-range select was accepted
err_clr  in  1  clears sel_err (synchronous)
occupancy  out  2  number of beats held (0..2)

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): out_valid=0, in_ready=1, sel_err=0, occupancy=0, out_data=0, both buffer entries cleared.
- Accept happens when in_valid & in_ready; emit happens when out_valid & out_ready.
- Selection on accept: in_data slice in_sel if in_sel<N, else DEFAULT_VAL. The selected value is stored; in_sel is not.
- Latency 1 cycle: a beat accepted at edge t appears on out_data/out_valid after edge t when the block was empty.
- Storage: main register (drives out_data) plus skid register.
  - in_ready = (occupancy<2), registered, never combinational from out_ready.
- States EMPTY(0), ONE(1), FULL(2):
  - EMPTY: accept -> ONE, main<=sel.
  - ONE:
    - accept & emit -> ONE, main<=sel.
    - accept only -> FULL, skid<=sel.
    - emit only -> EMPTY.
  - FULL (in_ready=0): emit -> ONE, main<=skid. No accept is possible.
- Order preserved; no beat dropped or duplicated. out_data is stable while out_valid & !out_ready.
- sel_err: set on an accepted beat with in_sel>=N. err_clr clears it.
  - Simultaneous set and clear: set wins.
  - in_sel>=N while in_valid=0 or in_ready=0 has no effect.
- in_valid with in_ready=0: the beat is not taken. Upstream must hold it.
- Reset mid-transfer discards buffered beats; no output follows reset until a new accept.
- N a power of two: sel_err can never set (the default path is unreachable, and that is legal).
- Elaboration error if N<2, N>16 or W<1.

Decomposition:
- Shared package mux_pkg holds:
  - occupancy state encoding (ST_EMPTY, ST_ONE, ST_FULL)
  - localparam helper for select width
  - MUX_MAX_N=16
- One sub-module, mux_sel_comb: purely combinational N-way select with default. It is reused by the existing 5-input sites as their replacement.
- mux_sel_pipe instantiates mux_sel_comb and adds the skid control.

Test Plan:
1. Reset then single beat:
   - Stimulus: N=5, W=32, inputs k=0x1000_0000+k, in_sel=3, in_valid for 1 cycle, out_ready=1.
   - Response: out_data=0x1000_0003 and out_valid=1 exactly 1 cycle later; occupancy returns to 0; sel_err=0.
2. Illegal select:
   - Stimulus: in_sel=6 (N=5), DEFAULT_VAL=0xDEAD_BEEF.
   - Response: out_data=0xDEAD_BEEF and sel_err=1.
   - Then err_clr pulse together with an accepted in_sel=7 beat: sel_err stays 1. Next err_clr alone: sel_err=0.
3. Backpressure/skid:
   - Stimulus: out_ready=0, stream sel=0,1,2 back-to-back.
   - Response: first two beats accepted, occupancy=2, in_ready=0 on third; out_data held at input0.
   - Release out_ready: outputs in order 0,1,2 with no loss.
4. Full throughput:
   - Stimulus: in_valid=out_ready=1 for 100 cycles with random legal sel.
   - Response: one beat per cycle after 1-cycle latency; scoreboard matches; occupancy never exceeds 1.
5. Reset mid-operation:
   - Stimulus: occupancy=2, assert reset_n low between clock edges.
   - Response: outputs clear immediately (asynchronous). After release, no stale beat appears.
6. Parameter sweep:
   - Configurations: N=2/W=1, N=8/W=16, N=16/W=64.
   - Response: random traffic with random stalls matches the model; N=8 never sets sel_err.
